// File: rtl/decode_stage.sv
// Fetch-to-decode boundary: small {pc, instruction} FIFO with RV32I field decode of the head entry.
// Flush from writeback empties the FIFO; handshakes on both sides are valid/ready.
module decode_stage #(
  parameter int unsigned INS_SIZE = 32,
  parameter int unsigned PC_SIZE  = 32,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_valid_i,
  output logic                         fetch_ready_o,
  input  logic [PC_SIZE-1:0]           fetch_pc_i,
  input  logic [INS_SIZE-1:0]          fetch_instruction_i,
  input  logic                         flush_i,
  output logic                         dec_valid_o,
  input  logic                         dec_ready_i,
  output logic [PC_SIZE-1:0]           dec_pc_o,
  output logic [6:0]                   dec_opcode_o,
  output logic [4:0]                   dec_rd_o,
  output logic [4:0]                   dec_rs1_o,
  output logic [4:0]                   dec_rs2_o,
  output logic [2:0]                   dec_funct3_o,
  output logic [6:0]                   dec_funct7_o,
  output logic [31:0]                  dec_imm_o,
  output logic                         dec_illegal_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PC_SIZE-1:0]  pc_mem_q  [DEPTH];
  logic [INS_SIZE-1:0] ins_mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push;
  logic                pop;
  logic [31:0]         ins;

  // Handshake flags come from the registered count only.
  assign fetch_ready_o = (count_q != CNT_W'(DEPTH));
  assign dec_valid_o   = (count_q != '0);
  assign occupancy_o   = count_q;

  assign push = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign pop  = dec_valid_o & dec_ready_i & ~flush_i;

  // Pointer and count next-state; flush wins over push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while count marks them live.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem_q[wr_ptr_q]  <= fetch_pc_i;
      ins_mem_q[wr_ptr_q] <= fetch_instruction_i;
    end
  end

  assign ins = ins_mem_q[rd_ptr_q][31:0];

  // Field and immediate decode of the head; everything reads zero while empty.
  always_comb begin
    dec_pc_o      = '0;
    dec_opcode_o  = '0;
    dec_rd_o      = '0;
    dec_rs1_o     = '0;
    dec_rs2_o     = '0;
    dec_funct3_o  = '0;
    dec_funct7_o  = '0;
    dec_imm_o     = '0;
    dec_illegal_o = 1'b0;
    if (dec_valid_o) begin
      dec_pc_o     = pc_mem_q[rd_ptr_q];
      dec_opcode_o = ins[6:0];
      dec_rd_o     = ins[11:7];
      dec_rs1_o    = ins[19:15];
      dec_rs2_o    = ins[24:20];
      dec_funct3_o = ins[14:12];
      dec_funct7_o = ins[31:25];
      case (ins[6:0])
        7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
          dec_imm_o = {{20{ins[31]}}, ins[31:20]};
        7'b0100011:
          dec_imm_o = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        7'b1100011:
          dec_imm_o = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        7'b0110111, 7'b0010111:
          dec_imm_o = {ins[31:12], 12'b0};
        7'b1101111:
          dec_imm_o = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        7'b0110011, 7'b0001111:
          dec_imm_o = '0;
        default:
          dec_illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver queues hand-computed decodes, negedge monitor checks pops.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_pc_i;
  logic [31:0] fetch_instruction_i;
  logic        flush_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_pc_o;
  logic [6:0]  dec_opcode_o;
  logic [4:0]  dec_rd_o;
  logic [4:0]  dec_rs1_o;
  logic [4:0]  dec_rs2_o;
  logic [2:0]  dec_funct3_o;
  logic [6:0]  dec_funct7_o;
  logic [31:0] dec_imm_o;
  logic        dec_illegal_o;
  logic [1:0]  occupancy_o;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  decode_stage #(.INS_SIZE(32), .PC_SIZE(32), .DEPTH(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_ready_o       (fetch_ready_o),
    .fetch_pc_i          (fetch_pc_i),
    .fetch_instruction_i (fetch_instruction_i),
    .flush_i             (flush_i),
    .dec_valid_o         (dec_valid_o),
    .dec_ready_i         (dec_ready_i),
    .dec_pc_o            (dec_pc_o),
    .dec_opcode_o        (dec_opcode_o),
    .dec_rd_o            (dec_rd_o),
    .dec_rs1_o           (dec_rs1_o),
    .dec_rs2_o           (dec_rs2_o),
    .dec_funct3_o        (dec_funct3_o),
    .dec_funct7_o        (dec_funct7_o),
    .dec_imm_o           (dec_imm_o),
    .dec_illegal_o       (dec_illegal_o),
    .occupancy_o         (occupancy_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm, input logic ill);
    exp_t e;
    e.pc = pc; e.opcode = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.f3 = f3; e.f7 = f7; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic offer(input logic [31:0] pc, input logic [31:0] ins, input exp_t e);
    int n = 0;
    fetch_valid_i       = 1'b1;
    fetch_pc_i          = pc;
    fetch_instruction_i = ins;
    while (!fetch_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      chk("offer_timeout", 32'(n), 32'd0);
    end else begin
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    fetch_valid_i = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a head consumed at the coming edge must match the oldest expectation.
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (!rst && dec_valid_o && dec_ready_i && !flush_i) begin
      act = mk(dec_pc_o, dec_opcode_o, dec_rd_o, dec_rs1_o, dec_rs2_o, dec_funct3_o,
               dec_funct7_o, dec_imm_o, dec_illegal_o);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected pc=0x%08h", dec_pc_o);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL pop_fields actual pc=%h op=%h rd=%h rs1=%h rs2=%h f3=%h f7=%h imm=%h ill=%b expected pc=%h op=%h rd=%h rs1=%h rs2=%h f3=%h f7=%h imm=%h ill=%b",
                   act.pc, act.opcode, act.rd, act.rs1, act.rs2, act.f3, act.f7, act.imm, act.ill,
                   e.pc, e.opcode, e.rd, e.rs1, e.rs2, e.f3, e.f7, e.imm, e.ill);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetch_valid_i = 1'b0; fetch_pc_i = '0; fetch_instruction_i = '0;
    flush_i = 1'b0; dec_ready_i = 1'b0;
    step(3);
    rst = 1'b0;

    chk("rst_fetch_ready", 32'(fetch_ready_o), 32'd1);
    chk("rst_dec_valid",   32'(dec_valid_o),   32'd0);
    chk("rst_occupancy",   32'(occupancy_o),   32'd0);
    chk("rst_pc",          dec_pc_o,           32'd0);
    chk("rst_opcode",      32'(dec_opcode_o),  32'd0);
    chk("rst_imm",         dec_imm_o,          32'd0);

    // Single addi, one-cycle latency, then popped.
    dec_ready_i = 1'b1;
    offer(32'h0, 32'h00500093, mk(32'h0, 7'h13, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'h5, 1'b0));
    chk("lat_dec_valid", 32'(dec_valid_o), 32'd1);
    chk("lat_occupancy", 32'(occupancy_o), 32'd1);
    step(1);
    chk("drain_dec_valid", 32'(dec_valid_o),  32'd0);
    chk("empty_opcode",    32'(dec_opcode_o), 32'd0);

    // Immediate formats, R-type and an illegal opcode streamed through.
    offer(32'h4,  32'hFE000EE3, mk(32'h4,  7'h63, 5'd29, 5'd0, 5'd0,  3'd0, 7'h7F, 32'hFFFFFFFC, 1'b0));
    offer(32'h8,  32'h12345137, mk(32'h8,  7'h37, 5'd2,  5'd8, 5'd3,  3'd5, 7'h09, 32'h12345000, 1'b0));
    offer(32'hC,  32'h0020A623, mk(32'hC,  7'h23, 5'd12, 5'd1, 5'd2,  3'd2, 7'h00, 32'd12,       1'b0));
    offer(32'h10, 32'h008000EF, mk(32'h10, 7'h6F, 5'd1,  5'd0, 5'd8,  3'd0, 7'h00, 32'd8,        1'b0));
    offer(32'h14, 32'hFFF28293, mk(32'h14, 7'h13, 5'd5,  5'd5, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0));
    offer(32'h18, 32'h002081B3, mk(32'h18, 7'h33, 5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 32'd0,        1'b0));
    offer(32'h1C, 32'h0000007F, mk(32'h1C, 7'h7F, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'd0,        1'b1));
    step(2);

    // Fill with consumer stalled, hold off a third offer, then drain in order.
    dec_ready_i = 1'b0;
    offer(32'h0, 32'h00500093, mk(32'h0, 7'h13, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'h5, 1'b0));
    offer(32'h4, 32'h002081B3, mk(32'h4, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 1'b0));
    chk("full_occupancy",   32'(occupancy_o),   32'd2);
    chk("full_fetch_ready", 32'(fetch_ready_o), 32'd0);
    fork
      offer(32'h8, 32'h12345137, mk(32'h8, 7'h37, 5'd2, 5'd8, 5'd3, 3'd5, 7'h09, 32'h12345000, 1'b0));
      begin
        step(3);
        chk("held_occupancy", 32'(occupancy_o), 32'd2);
        dec_ready_i = 1'b1;
      end
    join
    step(3);
    chk("after_drain_valid", 32'(dec_valid_o), 32'd0);

    // Flush while full with a live offer and a ready consumer.
    dec_ready_i = 1'b0;
    offer(32'h20, 32'h00500093, mk(32'h20, 7'h13, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'h5, 1'b0));
    offer(32'h24, 32'h002081B3, mk(32'h24, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 1'b0));
    fetch_valid_i = 1'b1; fetch_pc_i = 32'h100; fetch_instruction_i = 32'h00500093;
    flush_i = 1'b1; dec_ready_i = 1'b1;
    step(1);
    flush_i = 1'b0; fetch_valid_i = 1'b0; dec_ready_i = 1'b0;
    exp_q.delete();
    chk("flush_full_occupancy",   32'(occupancy_o),   32'd0);
    chk("flush_full_dec_valid",   32'(dec_valid_o),   32'd0);
    chk("flush_full_fetch_ready", 32'(fetch_ready_o), 32'd1);

    // Flush with room available: the offered instruction must still be dropped.
    offer(32'h30, 32'h00500093, mk(32'h30, 7'h13, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'h5, 1'b0));
    fetch_valid_i = 1'b1; fetch_pc_i = 32'h104; fetch_instruction_i = 32'h002081B3;
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0; fetch_valid_i = 1'b0;
    exp_q.delete();
    chk("flush_push_occupancy", 32'(occupancy_o), 32'd0);
    step(1);
    chk("flush_push_dropped", 32'(occupancy_o), 32'd0);

    // Ten back-to-back addi's with a ready consumer.
    dec_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(32'h200 + 32'(4 * i), {12'(i), 5'd0, 3'd0, 5'(i), 7'h13},
            mk(32'h200 + 32'(4 * i), 7'h13, 5'(i), 5'd0, 5'(i), 3'd0, 7'h00, 32'(i), 1'b0));
      chk("stream_occupancy", 32'(occupancy_o), 32'd1);
    end
    step(1);
    chk("stream_end_occupancy", 32'(occupancy_o), 32'd0);

    // Illegal head, then reset while it is held.
    dec_ready_i = 1'b0;
    offer(32'h300, 32'h0000007F, mk(32'h300, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 1'b1));
    chk("illegal_flag",   32'(dec_illegal_o), 32'd1);
    chk("illegal_opcode", 32'(dec_opcode_o),  32'h7F);
    rst = 1'b1;
    step(1);
    exp_q.delete();
    chk("mid_rst_occupancy",   32'(occupancy_o),   32'd0);
    chk("mid_rst_dec_valid",   32'(dec_valid_o),   32'd0);
    chk("mid_rst_fetch_ready", 32'(fetch_ready_o), 32'd1);
    chk("mid_rst_illegal",     32'(dec_illegal_o), 32'd0);
    chk("mid_rst_pc",          dec_pc_o,           32'd0);
    rst = 1'b0;
    step(2);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
